// File: rtl/stopwatch_bcd_counter.sv
// MM:SS stopwatch core: button edge detect, IDLE/RUN/HOLD run control,
// one-second prescaler and a four-digit BCD chain with registered outputs.
module stopwatch_bcd_counter #(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            ss_prev_q;
  logic [PW-1:0]   pre_q, pre_d;
  logic [3:0]      s1_q, s1_d, s10_q, s10_d, m1_q, m1_d, m10_q, m10_d;
  logic            running_q, running_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic            rise, clr_act, adv, inc;

  // Run control: next state, clear action and prescaler/increment qualifiers.
  always_comb begin
    rise    = start_stop & ~ss_prev_q;
    state_d = state_q;
    clr_act = 1'b0;
    case (state_q)
      IDLE: if (rise) state_d = RUN;
      RUN: begin
        if (clear)     clr_act = 1'b1;   // stays RUN, rise ignored
        else if (rise) state_d = HOLD;
      end
      HOLD: begin
        if (clear) begin
          clr_act = 1'b1;
          state_d = IDLE;
        end else if (rise) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    adv       = (state_q == RUN) & ~rise & ~clear;
    inc       = adv & (pre_q == PRE_MAX);
    running_d = (state_d == RUN);
  end

  // Prescaler: counts while running undisturbed, holds in HOLD so a
  // partial second survives a pause.
  always_comb begin
    pre_d = pre_q;
    if (clr_act)  pre_d = '0;
    else if (inc) pre_d = '0;
    else if (adv) pre_d = pre_q + 1'b1;
  end

  // BCD ripple chain, one step per increment; wrap flags the full rollover.
  always_comb begin
    s1_d   = s1_q;
    s10_d  = s10_q;
    m1_d   = m1_q;
    m10_d  = m10_q;
    wrap_d = 1'b0;
    tick_d = inc;
    if (clr_act) begin
      s1_d  = '0;
      s10_d = '0;
      m1_d  = '0;
      m10_d = '0;
    end else if (inc) begin
      if (s1_q >= 4'd9) begin
        s1_d = '0;
        if (s10_q >= 4'd5) begin
          s10_d = '0;
          if (m1_q >= 4'd9) begin
            m1_d = '0;
            if (m10_q >= 4'd5) begin
              m10_d  = '0;
              wrap_d = 1'b1;
            end else begin
              m10_d = m10_q + 4'd1;
            end
          end else begin
            m1_d = m1_q + 4'd1;
          end
        end else begin
          s10_d = s10_q + 4'd1;
        end
      end else begin
        s1_d = s1_q + 4'd1;
      end
    end
  end

  // State and output registers; ss_prev resets high so a held button is inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ss_prev_q <= 1'b1;
      pre_q     <= '0;
      s1_q      <= '0;
      s10_q     <= '0;
      m1_q      <= '0;
      m10_q     <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_prev_q <= start_stop;
      pre_q     <= pre_d;
      s1_q      <= s1_d;
      s10_q     <= s10_d;
      m1_q      <= m1_d;
      m10_q     <= m10_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign sec_ones = s1_q;
  assign sec_tens = s10_q;
  assign min_ones = m1_q;
  assign min_tens = m10_q;
  assign running  = running_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter: one instance at TICK_DIV=1 and
// one at TICK_DIV=4, expectations queued per step and checked after the edge.
module tb_stopwatch_bcd_counter;

  logic clk = 1'b0;
  logic rst, start_stop, clear;
  logic [3:0] so1, st1, mo1, mt1, so4, st4, mo4, mt4;
  logic run1, tick1, wrap1, run4, tick4, wrap4;

  int n_asrt = 0;
  int n_fail = 0;
  int secs_e = 0;

  typedef struct {
    string       tag;
    bit          d4;
    logic [15:0] dig;
    logic        run, tick, wrap;
  } exp_t;
  exp_t sb[$];

  stopwatch_bcd_counter #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
    .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
    .running(run1), .tick(tick1), .wrap(wrap1));

  stopwatch_bcd_counter #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
    .sec_ones(so4), .sec_tens(st4), .min_ones(mo4), .min_tens(mt4),
    .running(run4), .tick(tick4), .wrap(wrap4));

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] o, input logic [15:0] e);
    n_asrt++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, o, e);
    end
  endtask

  task automatic check_out();
    exp_t e;
    logic [15:0] dig;
    logic r, t, w;
    e = sb.pop_front();
    if (e.d4) begin
      dig = {mt4, mo4, st4, so4}; r = run4; t = tick4; w = wrap4;
    end else begin
      dig = {mt1, mo1, st1, so1}; r = run1; t = tick1; w = wrap1;
    end
    chk({e.tag, ".digits"}, dig, e.dig);
    chk({e.tag, ".running"}, {15'd0, r}, {15'd0, e.run});
    chk({e.tag, ".tick"}, {15'd0, t}, {15'd0, e.tick});
    chk({e.tag, ".wrap"}, {15'd0, w}, {15'd0, e.wrap});
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, check.
  task automatic cyc(input logic ss, input logic clr, input int secs,
                     input logic er, input logic et, input logic ew,
                     input bit d4, input string tag);
    exp_t e;
    start_stop = ss;
    clear      = clr;
    e.tag = tag; e.d4 = d4; e.dig = to_bcd(secs);
    e.run = er;  e.tick = et; e.wrap = ew;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // n running cycles on the TICK_DIV=1 instance: one second per cycle.
  task automatic run_n(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      secs_e = (secs_e + 1) % 3600;
      cyc(1'b0, 1'b0, secs_e, 1'b1, 1'b1, secs_e == 0, 1'b0, tag);
    end
  endtask

  initial begin
    int ph, s4;
    rst = 1'b1; start_stop = 1'b1; clear = 1'b0;

    // 1: reset with button held, then held on past reset
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "reset4");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "held_btn");

    // 2: basic count
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "release");
    cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "start");
    secs_e = 0;
    run_n(10, "to_0010");
    run_n(50, "to_0100");

    // 3: full rollover
    run_n(3599 - 60, "to_5959");
    run_n(1, "rollover");
    run_n(1, "post_wrap");

    // 4: pause at 00:25, wait, resume
    run_n(24, "to_0025");
    cyc(1'b1, 1'b0, 25, 1'b0, 1'b0, 1'b0, 1'b0, "stop");
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 25, 1'b0, 1'b0, 1'b0, 1'b0, "paused");
    cyc(1'b1, 1'b0, 25, 1'b1, 1'b0, 1'b0, 1'b0, "resume");
    run_n(1, "after_resume");

    // 5A: clear in HOLD at 01:07
    run_n(41, "to_0107");
    cyc(1'b1, 1'b0, 67, 1'b0, 1'b0, 1'b0, 1'b0, "stop_0107");
    cyc(1'b0, 1'b0, 67, 1'b0, 1'b0, 1'b0, 1'b0, "hold_0107");
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "clear_hold");
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "clear_idle");
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // 5B: clear together with a rise in RUN at 02:30, then clear held
    cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "restart");
    secs_e = 0;
    run_n(150, "to_0230");
    cyc(1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, "clear_rise_run");
    secs_e = 0;
    run_n(1, "after_clear_run");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, "clear_held");
    secs_e = 0;
    run_n(2, "after_clear_held");

    // reset mid-count with other inputs active
    rst = 1'b1;
    cyc(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "midrst");
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "midrst4");
    rst = 1'b0;

    // 6: TICK_DIV=4 prescaler, pause with a partial second pending
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "rel4");
    cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, "start4");
    ph = 0; s4 = 0;
    for (int i = 0; i < 10; i++) begin
      ph++;
      if (ph == 4) begin ph = 0; s4++; end
      cyc(1'b0, 1'b0, s4, 1'b1, ph == 0, 1'b0, 1'b1, "div4");
    end
    cyc(1'b1, 1'b0, s4, 1'b0, 1'b0, 1'b0, 1'b1, "stop4");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, s4, 1'b0, 1'b0, 1'b0, 1'b1, "hold4");
    cyc(1'b1, 1'b0, s4, 1'b1, 1'b0, 1'b0, 1'b1, "resume4");
    for (int i = 0; i < 6; i++) begin
      ph++;
      if (ph == 4) begin ph = 0; s4++; end
      cyc(1'b0, 1'b0, s4, 1'b1, ph == 0, 1'b0, 1'b1, "div4_resumed");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
